snn_ctrl: RTL and testbench

SNN_CTRL -- requirements
Module: snn_ctrl

---
 rtl/snn_pkg.sv | 17 +
 rtl/pixel_unpacker.sv | 72 +++++++
 rtl/snn_ctrl.sv | 92 +++++++++
 tb/tb_snn_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN digit-classifier controller.
package snn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_START   = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_TX_WAIT = 3'd4
   } state_t;

   localparam int         BYTES_PER_IMAGE = 98;
   localparam int         NUM_PIXELS      = BYTES_PER_IMAGE * 8;
   localparam logic [9:0] LAST_PIXEL      = 10'(NUM_PIXELS - 1);
   localparam logic [7:0] ASCII_ZERO      = 8'h30;

endpackage

// File: rtl/pixel_unpacker.sv
// Serialises received bytes into one pixel bit per cycle, LSB first, with a one-byte holding slot.
// A byte arriving while both the shift register and the holding slot are busy is dropped and flagged.
module pixel_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_en,
   input  logic       byte_vld,
   input  logic [7:0] byte_dat,
   output logic       pix_vld,
   output logic       pix_bit,
   output logic       drop
);

   logic [7:0] sr;
   logic [7:0] hold_dat;
   logic [2:0] bit_cnt;
   logic       active;
   logic       hold_full;
   logic       done_byte;
   logic       sr_free;
   logic       accept;

   assign done_byte = active && (bit_cnt == 3'd7);
   assign sr_free   = !active || done_byte;
   assign accept    = load_en && byte_vld;
   assign pix_vld   = active;
   assign pix_bit   = sr[0];
   assign drop      = accept && hold_full && !sr_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= 8'h00;
         hold_dat  <= 8'h00;
         bit_cnt   <= 3'd0;
         active    <= 1'b0;
         hold_full <= 1'b0;
      end else if (!load_en) begin
         active    <= 1'b0;
         hold_full <= 1'b0;
         bit_cnt   <= 3'd0;
      end else begin
         if (active) begin
            sr      <= {1'b0, sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (sr_free) begin
            // Holding slot drains first; a byte arriving in the same cycle refills it.
            if (hold_full) begin
               sr        <= hold_dat;
               bit_cnt   <= 3'd0;
               active    <= 1'b1;
               hold_full <= accept;
               if (accept) hold_dat <= byte_dat;
            end else if (accept && !active) begin
               sr      <= byte_dat;
               bit_cnt <= 3'd0;
               active  <= 1'b1;
            end else begin
               active <= 1'b0;
               if (accept) begin
                  hold_dat  <= byte_dat;
                  hold_full <= 1'b1;
               end
            end
         end else if (accept && !hold_full) begin
            hold_dat  <= byte_dat;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/snn_ctrl.sv
// Frame controller: UART bytes -> input RAM pixels, launches inference, reports the digit over UART.
// Pixel writes start the cycle after a byte is taken; core_start follows the last write by one cycle.
module snn_ctrl
   import snn_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   input  logic [9:0] core_addr,
   input  logic       core_done,
   input  logic [3:0] core_digit,
   input  logic       tx_busy,
   output logic [9:0] ram_addr,
   output logic       ram_data,
   output logic       ram_we,
   output logic       core_start,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [7:0] led,
   output logic       busy,
   output logic       overrun
);

   state_t     state;
   logic [9:0] pix_cnt;
   logic       load_en;
   logic       pix_vld;
   logic       pix_bit;
   logic       drop;

   assign load_en = (state == ST_IDLE) || (state == ST_LOAD);

   pixel_unpacker u_unpack (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (load_en),
      .byte_vld (rx_rdy),
      .byte_dat (rx_data),
      .pix_vld  (pix_vld),
      .pix_bit  (pix_bit),
      .drop     (drop)
   );

   assign ram_we     = (state == ST_LOAD) && pix_vld;
   assign ram_addr   = (state == ST_LOAD) ? pix_cnt : core_addr;
   assign ram_data   = ram_we & pix_bit;
   assign core_start = (state == ST_START);
   assign tx_start   = (state == ST_TX_WAIT) && !tx_busy;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pix_cnt <= 10'd0;
         led     <= 8'h00;
         tx_data <= 8'h00;
         overrun <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_rdy) begin
                  pix_cnt <= 10'd0;
                  overrun <= 1'b0;
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (ram_we) begin
                  if (pix_cnt == LAST_PIXEL) state <= ST_START;
                  else                       pix_cnt <= pix_cnt + 10'd1;
               end
            end
            ST_START: state <= ST_COMPUTE;
            ST_COMPUTE: begin
               if (core_done) begin
                  led     <= {4'h0, core_digit};
                  tx_data <= ASCII_ZERO + {4'h0, core_digit};
                  state   <= ST_TX_WAIT;
               end
            end
            ST_TX_WAIT: begin
               if (!tx_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // Bytes arriving while the frame is being classified or reported are lost.
         if ((rx_rdy && !load_en) || drop) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_snn_ctrl.sv
// Directed bench for snn_ctrl: frame loading, inference handshake, UART report, overrun and reset.
module tb_snn_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [9:0] core_addr = 10'd0;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = 4'd0;
   logic       tx_busy = 1'b0;
   logic [9:0] ram_addr;
   logic       ram_data;
   logic       ram_we;
   logic       core_start;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] led;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   snn_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .core_addr  (core_addr),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_busy    (tx_busy),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_we     (ram_we),
      .core_start (core_start),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .led        (led),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Write/pulse recorder sampled on the falling edge.
   logic       clr_mon = 1'b1;
   int         cyc = 0;
   int         wr_cnt, cs_cnt, tx_cnt, run, max_run, last_wr_cyc, cs_cyc;
   logic [9:0] last_wr_addr, first_wr_addr;
   logic [7:0] tx_seen;
   logic       prev_we;
   logic       wmem [0:783];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clr_mon) begin
         wr_cnt = 0; cs_cnt = 0; tx_cnt = 0; run = 0; max_run = 0;
         last_wr_cyc = 0; cs_cyc = 0; prev_we = 1'b0;
         last_wr_addr = 10'h3ff; first_wr_addr = 10'h3ff; tx_seen = 8'hxx;
         for (int i = 0; i < 784; i++) wmem[i] = 1'bx;
      end else begin
         if (ram_we) begin
            if (wr_cnt == 0) first_wr_addr = ram_addr;
            wr_cnt++;
            if (ram_addr < 10'd784) wmem[ram_addr] = ram_data;
            last_wr_addr = ram_addr;
            last_wr_cyc  = cyc;
            run = prev_we ? run + 1 : 1;
            if (run > max_run) max_run = run;
         end
         prev_we = ram_we;
         if (core_start) begin cs_cnt++; cs_cyc = cyc; end
         if (tx_start) begin tx_cnt++; tx_seen = tx_data; end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_rdy = 1'b1; rx_data = b;
      tick(1);
      rx_rdy = 1'b0;
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1; tick(1); clr_mon = 1'b0;
   endtask

   function automatic int count_bad(input logic [7:0] pat);
      int bad = 0;
      for (int i = 0; i < 784; i++)
         if (wmem[i] !== pat[i % 8]) bad++;
      return bad;
   endfunction

   initial begin
      logic [15:0] got16;

      // Reset values while rst_n is held low
      #2;
      chk("rst_ram_we",     32'(ram_we),     0);
      chk("rst_core_start", 32'(core_start), 0);
      chk("rst_tx_start",   32'(tx_start),   0);
      chk("rst_tx_data",    32'(tx_data),    0);
      chk("rst_led",        32'(led),        0);
      chk("rst_overrun",    32'(overrun),    0);
      chk("rst_busy",       32'(busy),       0);
      tick(3);
      rst_n = 1'b1; clr_mon = 1'b0;
      tick(2);

      // Full frame of 0xA5 with wide spacing
      for (int b = 0; b < 98; b++) begin
         send_byte(8'hA5);
         tick(199);
      end
      chk("a5_writes",      wr_cnt, 784);
      chk("a5_pattern_bad", count_bad(8'hA5), 0);
      chk("a5_addr0",       32'(wmem[0]), 1);
      chk("a5_addr1",       32'(wmem[1]), 0);
      chk("a5_addr7",       32'(wmem[7]), 1);
      chk("a5_last_addr",   32'(last_wr_addr), 783);
      chk("a5_core_starts", cs_cnt, 1);
      chk("a5_start_timing", cs_cyc, last_wr_cyc + 1);
      chk("a5_busy",        32'(busy), 1);

      core_addr = 10'h2AB;
      tick(1);
      chk("compute_ram_addr", 32'(ram_addr), 32'h2AB);
      chk("compute_ram_we",   32'(ram_we),   0);

      // Byte arriving during COMPUTE is ignored but flagged
      send_byte(8'h55);
      tick(2);
      chk("rx_in_compute_overrun", 32'(overrun), 1);
      chk("rx_in_compute_busy",    32'(busy),    1);
      chk("rx_in_compute_writes",  wr_cnt,       784);

      // Result 7 with transmitter free
      core_done = 1'b1; core_digit = 4'd7;
      tick(1);
      chk("d7_tx_start", 32'(tx_start), 1);
      chk("d7_tx_data",  32'(tx_data),  32'h37);
      chk("d7_led",      32'(led),      32'h07);
      core_done = 1'b0;
      tick(1);
      chk("d7_busy_after",  32'(busy),     0);
      chk("d7_tx_start_off", 32'(tx_start), 0);
      chk("d7_tx_count",    tx_cnt,         1);
      chk("d7_tx_seen",     32'(tx_seen),   32'h37);

      // Spurious core_done in IDLE
      core_done = 1'b1; core_digit = 4'd9;
      tick(1);
      core_done = 1'b0;
      tick(2);
      chk("spur_done_led",     32'(led),     32'h07);
      chk("spur_done_busy",    32'(busy),    0);
      chk("spur_done_overrun", 32'(overrun), 1);

      // Back-to-back bytes, third one dropped
      clear_mon();
      send_byte(8'h3C);
      chk("b2b_overrun_cleared", 32'(overrun), 0);
      send_byte(8'hC3);
      tick(1);
      send_byte(8'hFF);
      tick(30);
      for (int i = 0; i < 16; i++) got16[i] = wmem[i];
      chk("b2b_writes",     wr_cnt,        16);
      chk("b2b_run",        max_run,       16);
      chk("b2b_first_addr", 32'(first_wr_addr), 0);
      chk("b2b_bits",       32'(got16),    32'hC33C);
      chk("b2b_overrun",    32'(overrun),  1);

      // Reset after 40 bytes abandons the frame
      for (int b = 0; b < 38; b++) begin
         send_byte(8'h81);
         tick(9);
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",       32'(busy),       0);
      chk("mid_rst_ram_we",     32'(ram_we),     0);
      chk("mid_rst_overrun",    32'(overrun),    0);
      chk("mid_rst_led",        32'(led),        0);
      chk("mid_rst_tx_data",    32'(tx_data),    0);
      chk("mid_rst_core_start", 32'(core_start), 0);
      chk("mid_rst_tx_start",   32'(tx_start),   0);
      clr_mon = 1'b1;
      tick(2);
      rst_n = 1'b1; clr_mon = 1'b0;
      tick(2);

      // Fresh frame of 0x01 at 10-cycle spacing
      for (int b = 0; b < 98; b++) begin
         send_byte(8'h01);
         tick(9);
      end
      tick(20);
      chk("f01_first_addr",  32'(first_wr_addr), 0);
      chk("f01_writes",      wr_cnt,            784);
      chk("f01_pattern_bad", count_bad(8'h01),  0);
      chk("f01_core_starts", cs_cnt,            1);
      chk("f01_no_tx",       tx_cnt,            0);
      chk("f01_busy",        32'(busy),         1);

      // Result 3 while transmitter stays busy for 50 cycles
      tx_busy = 1'b1; core_done = 1'b1; core_digit = 4'd3;
      tick(1);
      core_done = 1'b0;
      tick(49);
      chk("d3_hold_tx_start", 32'(tx_start), 0);
      chk("d3_hold_tx_count", tx_cnt,        0);
      chk("d3_hold_busy",     32'(busy),     1);
      chk("d3_led",           32'(led),      32'h03);
      tx_busy = 1'b0;
      #1;
      chk("d3_tx_start", 32'(tx_start), 1);
      chk("d3_tx_data",  32'(tx_data),  32'h33);
      tick(1);
      chk("d3_tx_count", tx_cnt,        1);
      chk("d3_busy",     32'(busy),     0);
      chk("d3_tx_seen",  32'(tx_seen),  32'h33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
